multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the simplified MIPS datapath.
- Fetches a 16-bit instruction over a req/ack handshake, latches it, decodes the 4-bit opcode and steps the datapath through EXECUTE and WRITEBACK.
- Drives the register-file write enable, ALU operation select and ALU operand-B select only in the correct phase.
- Owns the PC, HALT handling and retired/illegal instruction counters.

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle sequencer for the simplified MIPS datapath. It fetches one
// 16-bit instruction at a time over a req/ack handshake, latches it, decodes
// the 4-bit opcode and steps the datapath through EXECUTE and WRITEBACK.
// It owns the program counter, HALT handling and the retired/illegal
// instruction counters.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle pulse, leaves IDLE (ignored elsewhere)
//   imem_ack     in   instruction memory data valid this cycle
//   imem_rdata   in   instruction [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd/imm
//   imem_req     out  fetch request (high throughout FETCH)
//   imem_addr    out  fetch address, equal to the program counter
//   instr        out  latched instruction register
//   reg_write    out  register-file write enable (WRITEBACK only)
//   alu_control  out  ALU operation select (EXECUTE/WRITEBACK only)
//   alu_src      out  ALU operand B: 0 = rt register, 1 = zero-extended imm
//   busy         out  high in any state other than IDLE and HALTED
//   halted       out  HALT has been executed
//   retired_cnt  out  instructions completed including HALT (saturating)
//   illegal_cnt  out  undefined opcodes skipped (saturating)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 imem_ack,
    input  logic [15:0]          imem_rdata,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic [15:0]          instr,
    output logic                 reg_write,
    output logic [3:0]           alu_control,
    output logic                 alu_src,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired_cnt,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t               r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [15:0]          r_instr;
    logic                 r_imem_req;
    logic                 r_reg_write;
    logic [3:0]           r_alu_control;
    logic                 r_alu_src;
    logic                 r_halted;
    logic [CNT_WIDTH-1:0] r_retired_cnt;
    logic [CNT_WIDTH-1:0] r_illegal_cnt;

    logic [3:0]           w_opcode;
    logic                 w_legal;
    logic [3:0]           w_alu_control;
    logic                 w_alu_src;

    // Decode works only from the latched instruction register, so there is
    // never a combinational path from imem_rdata to any control output.
    assign w_opcode = r_instr[15:12];

    always_comb begin
        w_legal       = 1'b1;
        w_alu_control = 4'b0000;
        w_alu_src     = 1'b0;
        unique case (w_opcode)
            OP_ADD:  w_alu_control = 4'b0010;
            OP_ADDI: begin
                w_alu_control = 4'b0010;
                w_alu_src     = 1'b1;
            end
            OP_SUB:  w_alu_control = 4'b0110;
            OP_AND:  w_alu_control = 4'b0000;
            OP_OR:   w_alu_control = 4'b0001;
            default: w_legal = 1'b0;
        endcase
    end

    // Sequencer. Every control output is a register that is set on the edge
    // entering the phase in which it must be valid, so it lines up exactly
    // with the state. Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_imem_req    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_alu_control <= 4'b0000;
            r_alu_src     <= 1'b0;
            r_halted      <= 1'b0;
            r_retired_cnt <= '0;
            r_illegal_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_pc       <= r_pc + PC_WIDTH'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (w_opcode == OP_HALT) begin
                        r_halted <= 1'b1;
                        if (r_retired_cnt != '1) begin
                            r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
                        end
                        r_state <= S_HALTED;
                    end else if (w_legal) begin
                        r_alu_control <= w_alu_control;
                        r_alu_src     <= w_alu_src;
                        r_state       <= S_EXECUTE;
                    end else begin
                        // Undefined opcode: skip it without writing or retiring.
                        if (r_illegal_cnt != '1) begin
                            r_illegal_cnt <= r_illegal_cnt + CNT_WIDTH'(1);
                        end
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end

                S_EXECUTE: begin
                    r_reg_write <= 1'b1;
                    r_state     <= S_WRITEBACK;
                end

                S_WRITEBACK: begin
                    r_reg_write   <= 1'b0;
                    r_alu_control <= 4'b0000;
                    r_alu_src     <= 1'b0;
                    if (r_retired_cnt != '1) begin
                        r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
                    end
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end

                S_HALTED: begin
                    r_state <= S_HALTED;
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_imem_req    <= 1'b0;
                    r_reg_write   <= 1'b0;
                    r_alu_control <= 4'b0000;
                    r_alu_src     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign reg_write   = r_reg_write;
    assign alu_control = r_alu_control;
    assign alu_src     = r_alu_src;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign halted      = r_halted;
    assign retired_cnt = r_retired_cnt;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Two instances share all inputs:
// one with default widths and one with PC_WIDTH=2/CNT_WIDTH=2 so that PC
// wrap and counter saturation can be seen. Inputs change on the falling
// edge and outputs are sampled there, half a cycle from the active edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] instr;
    logic        reg_write;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic        busy;
    logic        halted;
    logic [15:0] retired_cnt;
    logic [15:0] illegal_cnt;

    logic        sImemReq;
    logic [1:0]  sImemAddr;
    logic [15:0] sInstr;
    logic        sRegWrite;
    logic [3:0]  sAluControl;
    logic        sAluSrc;
    logic        sBusy;
    logic        sHalted;
    logic [1:0]  sRetiredCnt;
    logic [1:0]  sIllegalCnt;

    int errors = 0;
    int checks = 0;

    multicycle_controller #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .reg_write   (reg_write),
        .alu_control (alu_control),
        .alu_src     (alu_src),
        .busy        (busy),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
    );

    multicycle_controller #(.PC_WIDTH(2), .CNT_WIDTH(2)) dutSmall (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (sImemReq),
        .imem_addr   (sImemAddr),
        .instr       (sInstr),
        .reg_write   (sRegWrite),
        .alu_control (sAluControl),
        .alu_src     (sAluSrc),
        .busy        (sBusy),
        .halted      (sHalted),
        .retired_cnt (sRetiredCnt),
        .illegal_cnt (sIllegalCnt)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse start for one cycle; the controller is in FETCH afterwards.
    task automatic applyStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one ALU instruction from the FETCH cycle through WRITEBACK and
    // back into the next FETCH, checking every phase.
    task automatic applyStimulus(input logic [15:0] word, input int waitCycles,
                                 input logic [3:0] expAlu, input logic expSrc,
                                 input logic [7:0] expPc);
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("reqWait", imem_req, 1);
            checkOutput("addrWait", imem_addr, expPc);
            @(negedge clk);
        end
        checkOutput("reqAck", imem_req, 1);
        checkOutput("addrAck", imem_addr, expPc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        // DECODE
        checkOutput("decInstr", instr, word);
        checkOutput("decReq", imem_req, 0);
        checkOutput("decPc", imem_addr, expPc + 8'd1);
        checkOutput("decRegWrite", reg_write, 0);
        checkOutput("decAlu", alu_control, 0);
        checkOutput("decBusy", busy, 1);
        @(negedge clk);
        // EXECUTE
        checkOutput("exAlu", alu_control, expAlu);
        checkOutput("exSrc", alu_src, expSrc);
        checkOutput("exRegWrite", reg_write, 0);
        @(negedge clk);
        // WRITEBACK
        checkOutput("wbAlu", alu_control, expAlu);
        checkOutput("wbSrc", alu_src, expSrc);
        checkOutput("wbRegWrite", reg_write, 1);
        @(negedge clk);
        // next FETCH
        checkOutput("nextRegWrite", reg_write, 0);
        checkOutput("nextAlu", alu_control, 0);
        checkOutput("nextSrc", alu_src, 0);
        checkOutput("nextReq", imem_req, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rstReq", imem_req, 0);
        checkOutput("rstAddr", imem_addr, 0);
        checkOutput("rstInstr", instr, 0);
        checkOutput("rstRegWrite", reg_write, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstHalted", halted, 0);
        checkOutput("rstRetired", retired_cnt, 0);
        checkOutput("rstIllegal", illegal_cnt, 0);
        checkOutput("rstSmallRetired", sRetiredCnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleBusy", busy, 0);

        // Reset while a fetch is outstanding; a late ack must be ignored.
        applyStart();
        checkOutput("fetchReq", imem_req, 1);
        checkOutput("fetchBusy", busy, 1);
        @(negedge clk);
        checkOutput("fetchHoldReq", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstReq", imem_req, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstAddr", imem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h0123;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("lateAckInstr", instr, 0);
        checkOutput("lateAckReq", imem_req, 0);
        checkOutput("lateAckBusy", busy, 0);
        checkOutput("lateAckPc", imem_addr, 0);

        // ADD with zero-wait memory.
        applyStart();
        applyStimulus(16'h0123, 0, 4'b0010, 1'b0, 8'd0);
        checkOutput("addRetired", retired_cnt, 1);
        checkOutput("addPc", imem_addr, 1);

        // ADDI with the ack held off for three cycles.
        applyStimulus(16'h1125, 3, 4'b0010, 1'b1, 8'd1);
        checkOutput("addiRetired", retired_cnt, 2);

        // Undefined opcode 0x7 followed by SUB.
        imem_ack   = 1'b1;
        imem_rdata = 16'h7123;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("illDecRegWrite", reg_write, 0);
        @(negedge clk);
        checkOutput("illIllegal", illegal_cnt, 1);
        checkOutput("illRegWrite", reg_write, 0);
        checkOutput("illRetired", retired_cnt, 2);
        checkOutput("illReq", imem_req, 1);
        applyStimulus(16'h2123, 0, 4'b0110, 1'b0, 8'd3);
        checkOutput("subRetired", retired_cnt, 3);
        checkOutput("subIllegal", illegal_cnt, 1);

        // Program ADD, OR, HALT from a fresh reset.
        applyReset();
        applyStart();
        applyStimulus(16'h0123, 0, 4'b0010, 1'b0, 8'd0);
        applyStimulus(16'h4123, 0, 4'b0001, 1'b0, 8'd1);
        imem_ack   = 1'b1;
        imem_rdata = 16'hF000;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        checkOutput("haltHalted", halted, 1);
        checkOutput("haltBusy", busy, 0);
        checkOutput("haltReq", imem_req, 0);
        checkOutput("haltRetired", retired_cnt, 3);
        checkOutput("haltPc", imem_addr, 3);
        start      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h0123;
        repeat (3) @(negedge clk);
        start    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        checkOutput("postHaltHalted", halted, 1);
        checkOutput("postHaltBusy", busy, 0);
        checkOutput("postHaltReq", imem_req, 0);
        checkOutput("postHaltRetired", retired_cnt, 3);
        checkOutput("postHaltPc", imem_addr, 3);
        checkOutput("postHaltInstr", instr, 16'hF000);

        // Five ADDs: 2-bit PC wraps, 2-bit counter saturates.
        applyReset();
        applyStart();
        for (int k = 0; k < 5; k++) begin
            checkOutput("wrapAddr", sImemAddr, k % 4);
            checkOutput("satRetired", sRetiredCnt, (k < 3) ? k : 3);
            applyStimulus(16'h0123, 0, 4'b0010, 1'b0, 8'(k));
        end
        checkOutput("satRetiredEnd", sRetiredCnt, 3);
        checkOutput("wrapAddrEnd", sImemAddr, 1);
        checkOutput("wideRetiredEnd", retired_cnt, 5);
        checkOutput("widePcEnd", imem_addr, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
